// File: rtl/mem_loader_pkg.sv
// Shared definitions for the host-driven memory loader: FSM states,
// host command codes, watchdog default and small decode helpers.
package mem_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_I_LEN   = 4'd1,
    ST_I_DATA  = 4'd2,
    ST_D_AH    = 4'd3,
    ST_D_AL    = 4'd4,
    ST_D_LH    = 4'd5,
    ST_D_LL    = 4'd6,
    ST_D_DATA  = 4'd7,
    ST_RUN_RST = 4'd8,
    ST_RUN     = 4'd9,
    ST_DONE    = 4'd10
  } ld_state_e;

  localparam logic [7:0]  CMD_LOAD_I = 8'h01;
  localparam logic [7:0]  CMD_LOAD_D = 8'h02;
  localparam logic [7:0]  CMD_RUN    = 8'h03;

  localparam logic [19:0] WDOG_CYCLES_DEFAULT = 20'hFFFFF;

  // States in which the loader is listening to the host byte stream.
  function automatic logic state_accepts(input ld_state_e st);
    logic acc;
    case (st)
      ST_IDLE, ST_I_LEN, ST_I_DATA, ST_D_AH, ST_D_AL,
      ST_D_LH, ST_D_LL, ST_D_DATA: acc = 1'b1;
      default:                     acc = 1'b0;
    endcase
    return acc;
  endfunction

  // True for the three command bytes the loader understands.
  function automatic logic is_command(input logic [7:0] b);
    return (b == CMD_LOAD_I) || (b == CMD_LOAD_D) || (b == CMD_RUN);
  endfunction

endpackage

// File: rtl/mem_loader_wdog.sv
// Run watchdog: counts enabled cycles and flags the cycle in which the
// run reaches its budget, so a run lasts exactly LIMIT enabled cycles.
// LIMIT = 0 disables expiry.
module mem_loader_wdog
  import mem_loader_pkg::*;
#(
  parameter logic [19:0] LIMIT = WDOG_CYCLES_DEFAULT
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [19:0] count_r;
  logic [20:0] count_next_s;

  assign count_next_s = {1'b0, count_r} + 21'd1;

  // Cycle counter: cleared outside a run, saturates instead of wrapping.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_r <= 20'd0;
    end else if (clear) begin
      count_r <= 20'd0;
    end else if (enable && (count_r != 20'hFFFFF)) begin
      count_r <= count_next_s[19:0];
    end else begin
      count_r <= count_r;
    end
  end

  // Expiry fires in the enabled cycle whose increment reaches the budget.
  always_comb begin
    expire = 1'b0;
    if (enable && (LIMIT != 20'd0) && (count_next_s == {1'b0, LIMIT})) begin
      expire = 1'b1;
    end else begin
      expire = 1'b0;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Host byte-stream loader: fills instruction and data RAM, then runs the
// CPU under a watchdog and reports done / err / timeout to the host.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter logic [19:0] WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        inst_w,
  output logic [7:0]  inst_addr,
  output logic [7:0]  inst_din,
  output logic        data_w,
  output logic [15:0] data_addr,
  output logic [7:0]  data_din,
  output logic        mem_own,
  output logic        cpu_enable,
  output logic        cpu_reset,
  input  logic        cpu_finish,
  output logic        done,
  output logic        err,
  output logic        timeout
);

  ld_state_e   state_r;
  ld_state_e   state_s;
  logic        accept_s;
  logic        in_run_s;
  logic        wdog_expire_s;
  logic [16:0] cnt_r;
  logic [15:0] ptr_r;

  // Handshake and ownership decode. Reset overrides combinationally so the
  // RAM ports and CPU are safe during the reset cycle itself.
  assign in_run_s   = (state_r == ST_RUN);
  assign rx_ready   = state_accepts(state_r) & ~reset;
  assign accept_s   = rx_valid & rx_ready;
  assign mem_own    = ~in_run_s | reset;
  assign cpu_reset  = ~in_run_s | reset;
  assign cpu_enable = in_run_s & ~reset;

  mem_loader_wdog #(
    .LIMIT (WDOG_CYCLES)
  ) u_wdog (
    .clk_in (clk_in),
    .reset  (reset),
    .clear  (~in_run_s),
    .enable (in_run_s),
    .expire (wdog_expire_s)
  );

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: protocol sequencing and run termination.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (rx_data == CMD_LOAD_I) begin
            state_s = ST_I_LEN;
          end else if (rx_data == CMD_LOAD_D) begin
            state_s = ST_D_AH;
          end else if (rx_data == CMD_RUN) begin
            state_s = ST_RUN_RST;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_I_LEN: begin
        if (accept_s) begin
          state_s = ST_I_DATA;
        end else begin
          state_s = ST_I_LEN;
        end
      end
      ST_I_DATA, ST_D_DATA: begin
        if (accept_s && (cnt_r == 17'd1)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      ST_D_AH: begin
        if (accept_s) begin
          state_s = ST_D_AL;
        end else begin
          state_s = ST_D_AH;
        end
      end
      ST_D_AL: begin
        if (accept_s) begin
          state_s = ST_D_LH;
        end else begin
          state_s = ST_D_AL;
        end
      end
      ST_D_LH: begin
        if (accept_s) begin
          state_s = ST_D_LL;
        end else begin
          state_s = ST_D_LH;
        end
      end
      ST_D_LL: begin
        if (accept_s) begin
          // A zero-length data load carries no payload bytes.
          if ({cnt_r[15:8], rx_data} == 16'h0000) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_D_DATA;
          end
        end else begin
          state_s = ST_D_LL;
        end
      end
      ST_RUN_RST: begin
        state_s = ST_RUN;
      end
      ST_RUN: begin
        // Finish wins over a simultaneous watchdog expiry.
        if (cpu_finish || wdog_expire_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Load datapath: byte counter, address pointer and registered RAM writes.
  // Strobes are single-cycle pulses in the cycle after the byte is accepted.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_r     <= 17'd0;
      ptr_r     <= 16'h0000;
      inst_w    <= 1'b0;
      inst_addr <= 8'h00;
      inst_din  <= 8'h00;
      data_w    <= 1'b0;
      data_addr <= 16'h0000;
      data_din  <= 8'h00;
    end else begin
      inst_w <= 1'b0;
      data_w <= 1'b0;
      if (accept_s) begin
        case (state_r)
          ST_I_LEN: begin
            cnt_r <= (rx_data == 8'h00) ? 17'd256 : {9'd0, rx_data};
            ptr_r <= 16'h0000;
          end
          ST_I_DATA: begin
            inst_w    <= 1'b1;
            inst_addr <= ptr_r[7:0];
            inst_din  <= rx_data;
            ptr_r     <= ptr_r + 16'd1;
            cnt_r     <= cnt_r - 17'd1;
          end
          ST_D_AH: begin
            ptr_r[15:8] <= rx_data;
          end
          ST_D_AL: begin
            ptr_r[7:0] <= rx_data;
          end
          ST_D_LH: begin
            cnt_r <= {1'b0, rx_data, 8'h00};
          end
          ST_D_LL: begin
            cnt_r <= {1'b0, cnt_r[15:8], rx_data};
          end
          ST_D_DATA: begin
            data_w    <= 1'b1;
            data_addr <= ptr_r;
            data_din  <= rx_data;
            ptr_r     <= ptr_r + 16'd1;
            cnt_r     <= cnt_r - 17'd1;
          end
          default: begin
            cnt_r <= cnt_r;
          end
        endcase
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Sticky status flags: cleared by any command byte, set by a bad command
  // or by the end of a run.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      done    <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
    end else if ((state_r == ST_IDLE) && accept_s) begin
      done    <= 1'b0;
      timeout <= 1'b0;
      err     <= ~is_command(rx_data);
    end else if (in_run_s) begin
      if (cpu_finish) begin
        done <= 1'b1;
      end else if (wdog_expire_s) begin
        timeout <= 1'b1;
      end else begin
        done <= done;
      end
    end else begin
      done <= done;
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader. Instance A uses the default watchdog,
// instance B a 5-cycle watchdog for the expiry / priority cases.
module tb_mem_loader;
  import mem_loader_pkg::*;

  typedef struct {
    logic        is_data;
    logic [15:0] addr;
    logic [7:0]  din;
    int unsigned cyc;
  } wr_t;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid_a = 1'b0, rx_valid_b = 1'b0;
  logic        cpu_finish_a = 1'b0, cpu_finish_b = 1'b0;

  logic        rx_ready_a, inst_w_a, data_w_a, mem_own_a, cpu_enable_a, cpu_reset_a;
  logic        done_a, err_a, timeout_a;
  logic [7:0]  inst_addr_a, inst_din_a, data_din_a;
  logic [15:0] data_addr_a;
  logic        rx_ready_b, inst_w_b, data_w_b, mem_own_b, cpu_enable_b, cpu_reset_b;
  logic        done_b, err_b, timeout_b;
  logic [7:0]  inst_addr_b, inst_din_b, data_din_b;
  logic [15:0] data_addr_b;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  wr_t         sb[$];

  always #5 clk_in = ~clk_in;

  // Cycle index, advanced on each active edge.
  always @(posedge clk_in) cyc <= cyc + 1;

  mem_loader dut_a (
    .clk_in(clk_in), .reset(reset), .rx_valid(rx_valid_a), .rx_data(rx_data),
    .rx_ready(rx_ready_a), .inst_w(inst_w_a), .inst_addr(inst_addr_a),
    .inst_din(inst_din_a), .data_w(data_w_a), .data_addr(data_addr_a),
    .data_din(data_din_a), .mem_own(mem_own_a), .cpu_enable(cpu_enable_a),
    .cpu_reset(cpu_reset_a), .cpu_finish(cpu_finish_a), .done(done_a),
    .err(err_a), .timeout(timeout_a)
  );

  mem_loader #(.WDOG_CYCLES(20'd5)) dut_b (
    .clk_in(clk_in), .reset(reset), .rx_valid(rx_valid_b), .rx_data(rx_data),
    .rx_ready(rx_ready_b), .inst_w(inst_w_b), .inst_addr(inst_addr_b),
    .inst_din(inst_din_b), .data_w(data_w_b), .data_addr(data_addr_b),
    .data_din(data_din_b), .mem_own(mem_own_b), .cpu_enable(cpu_enable_b),
    .cpu_reset(cpu_reset_b), .cpu_finish(cpu_finish_b), .done(done_b),
    .err(err_b), .timeout(timeout_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every strobe of instance A must match the next
  // expected write, including the cycle in which it appears.
  always @(negedge clk_in) begin
    wr_t e;
    if (inst_w_a || data_w_a) begin
      check_val("w_mem_own", {31'd0, mem_own_a}, 32'd1);
      check_val("w_exclusive", {31'd0, inst_w_a & data_w_a}, 32'd0);
      if (sb.size() == 0) begin
        check_val("w_unexpected", {31'd0, inst_w_a | data_w_a}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("w_kind", {31'd0, data_w_a}, {31'd0, e.is_data});
        check_val("w_addr", data_w_a ? {16'd0, data_addr_a} : {24'd0, inst_addr_a}, {16'd0, e.addr});
        check_val("w_din", data_w_a ? {24'd0, data_din_a} : {24'd0, inst_din_a}, {24'd0, e.din});
        check_val("w_cycle", cyc, e.cyc);
      end
    end
    if (inst_w_b || data_w_b) begin
      check_val("b_unexpected", {31'd0, inst_w_b | data_w_b}, 32'd0);
    end
  end

  // Present one byte to instance tgt (0=A, 1=B); returns #1 after the
  // accepting edge. An expected write is queued for the following cycle.
  task automatic send(input logic tgt, input logic [7:0] b, input logic exp_w,
                      input logic exp_data, input logic [15:0] exp_addr);
    int n;
    wr_t e;
    @(negedge clk_in);
    rx_data = b;
    if (tgt) rx_valid_b = 1'b1; else rx_valid_a = 1'b1;
    n = 0;
    while (((tgt ? rx_ready_b : rx_ready_a) !== 1'b1) && (n < 64)) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 64) begin
      check_val("rx_ready_wait", {31'd0, tgt ? rx_ready_b : rx_ready_a}, 32'd1);
      rx_valid_a = 1'b0;
      rx_valid_b = 1'b0;
    end else begin
      @(posedge clk_in);
      #1;
      rx_valid_a = 1'b0;
      rx_valid_b = 1'b0;
      if (exp_w) begin
        e.is_data = exp_data;
        e.addr    = exp_addr;
        e.din     = b;
        e.cyc     = cyc;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input string tag);
    repeat (2) @(negedge clk_in);
    check_val(tag, sb.size(), 32'd0);
    check_val({tag, "_idle"}, {31'd0, rx_ready_a}, 32'd1);
  endtask

  // Issue a run command; assert finish in RUN cycle fin_at (0 = never).
  // A stray byte is held on rx during the run and must not be consumed.
  task automatic do_run(input logic tgt, input int fin_at, output int n);
    int k;
    send(tgt, CMD_RUN, 1'b0, 1'b0, 16'h0000);
    @(negedge clk_in);
    check_val("rr_cpu_reset", {31'd0, tgt ? cpu_reset_b : cpu_reset_a}, 32'd1);
    check_val("rr_cpu_enable", {31'd0, tgt ? cpu_enable_b : cpu_enable_a}, 32'd0);
    check_val("rr_rx_ready", {31'd0, tgt ? rx_ready_b : rx_ready_a}, 32'd0);
    check_val("rr_flags", {29'd0, tgt ? {done_b, err_b, timeout_b} : {done_a, err_a, timeout_a}}, 32'd0);
    rx_data = 8'h7E;
    if (tgt) rx_valid_b = 1'b1; else rx_valid_a = 1'b1;
    n = 0;
    k = 0;
    while (k < 200) begin
      @(negedge clk_in);
      k++;
      if (tgt ? cpu_enable_b : cpu_enable_a) begin
        n++;
        check_val("run_mem_own", {31'd0, tgt ? mem_own_b : mem_own_a}, 32'd0);
        check_val("run_cpu_reset", {31'd0, tgt ? cpu_reset_b : cpu_reset_a}, 32'd0);
        if (n == 1) check_val("run_rx_ready", {31'd0, tgt ? rx_ready_b : rx_ready_a}, 32'd0);
        if (n == fin_at) begin
          if (tgt) cpu_finish_b = 1'b1; else cpu_finish_a = 1'b1;
        end
      end else begin
        break;
      end
    end
    cpu_finish_a = 1'b0;
    cpu_finish_b = 1'b0;
    check_val("done_mem_own", {31'd0, tgt ? mem_own_b : mem_own_a}, 32'd1);
    check_val("done_rx_ready", {31'd0, tgt ? rx_ready_b : rx_ready_a}, 32'd0);
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
    @(negedge clk_in);
    check_val("post_run_idle", {31'd0, tgt ? rx_ready_b : rx_ready_a}, 32'd1);
    check_val("post_run_err", {31'd0, tgt ? err_b : err_a}, 32'd0);
  endtask

  initial begin
    int n;
    // Reset state, including the forced outputs during reset.
    repeat (3) @(negedge clk_in);
    check_val("rst_rx_ready", {31'd0, rx_ready_a}, 32'd0);
    check_val("rst_cpu_reset", {31'd0, cpu_reset_a}, 32'd1);
    check_val("rst_mem_own", {31'd0, mem_own_a}, 32'd1);
    @(posedge clk_in);
    #1 reset = 1'b0;
    @(negedge clk_in);
    check_val("rst_strobes", {30'd0, inst_w_a, data_w_a}, 32'd0);
    check_val("rst_flags", {29'd0, done_a, err_a, timeout_a}, 32'd0);
    check_val("rst_cpu_enable", {31'd0, cpu_enable_a}, 32'd0);
    check_val("rst_addr", {8'd0, inst_addr_a, data_addr_a}, 32'd0);
    check_val("rst_idle_ready", {31'd0, rx_ready_a}, 32'd1);

    // Three instruction bytes.
    send(1'b0, CMD_LOAD_I, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h03, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'hAA, 1'b1, 1'b0, 16'h0000);
    send(1'b0, 8'hBB, 1'b1, 1'b0, 16'h0001);
    send(1'b0, 8'hCC, 1'b1, 1'b0, 16'h0002);
    drain("iload3");

    // Data load across the 16-bit address wrap.
    send(1'b0, CMD_LOAD_D, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'hFF, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'hFF, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h02, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h11, 1'b1, 1'b1, 16'hFFFF);
    send(1'b0, 8'h22, 1'b1, 1'b1, 16'h0000);
    drain("dwrap");

    // Zero-length data load carries no payload.
    send(1'b0, CMD_LOAD_D, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h12, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h34, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
    drain("dzero");
    check_val("dzero_err", {31'd0, err_a}, 32'd0);

    // Run finished by the CPU in its 10th cycle.
    do_run(1'b0, 10, n);
    check_val("run10_len", n, 32'd10);
    check_val("run10_done", {31'd0, done_a}, 32'd1);
    check_val("run10_timeout", {31'd0, timeout_a}, 32'd0);

    // Watchdog expiry after 5 cycles, then finish coinciding with expiry.
    do_run(1'b1, 0, n);
    check_val("wd_len", n, 32'd5);
    check_val("wd_timeout", {31'd0, timeout_b}, 32'd1);
    check_val("wd_done", {31'd0, done_b}, 32'd0);
    do_run(1'b1, 5, n);
    check_val("prio_len", n, 32'd5);
    check_val("prio_done", {31'd0, done_b}, 32'd1);
    check_val("prio_timeout", {31'd0, timeout_b}, 32'd0);

    // Bad command, then a full 256-byte instruction load clears err.
    send(1'b0, 8'h7E, 1'b0, 1'b0, 16'h0000);
    @(negedge clk_in);
    check_val("bad_err", {31'd0, err_a}, 32'd1);
    check_val("bad_idle", {31'd0, rx_ready_a}, 32'd1);
    send(1'b0, CMD_LOAD_I, 1'b0, 1'b0, 16'h0000);
    @(negedge clk_in);
    check_val("cmd_clears_err", {31'd0, err_a}, 32'd0);
    check_val("cmd_clears_done", {31'd0, done_a}, 32'd0);
    send(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 256; i++) begin
      send(1'b0, 8'(i) ^ 8'h5A, 1'b1, 1'b0, 16'(i));
    end
    drain("iload256");

    // Reset after two of three data bytes aborts the load.
    send(1'b0, CMD_LOAD_D, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h10, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h03, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h11, 1'b1, 1'b1, 16'h0010);
    send(1'b0, 8'h22, 1'b1, 1'b1, 16'h0011);
    reset = 1'b1;
    rx_data = 8'h33;
    rx_valid_a = 1'b1;
    @(negedge clk_in);
    check_val("mid_rst_cpu_reset", {31'd0, cpu_reset_a}, 32'd1);
    check_val("mid_rst_rx_ready", {31'd0, rx_ready_a}, 32'd0);
    check_val("mid_rst_mem_own", {31'd0, mem_own_a}, 32'd1);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    rx_valid_a = 1'b0;
    @(negedge clk_in);
    check_val("post_rst_data_w", {31'd0, data_w_a}, 32'd0);
    check_val("post_rst_data_addr", {16'd0, data_addr_a}, 32'd0);
    drain("abort");
    send(1'b0, CMD_LOAD_I, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h01, 1'b0, 1'b0, 16'h0000);
    send(1'b0, 8'h5A, 1'b1, 1'b0, 16'h0000);
    drain("after_abort");
    check_val("final_err", {31'd0, err_a}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
